// File: rtl/rx_uart.sv
// -----------------------------------------------------------------------------
// rx_uart
//   UART receiver using a 16x oversampling baud tick. Recovers serial frames
//   from the RX pin: start bit, DBIT data bits (LSB first), optional even
//   parity bit and one stop bit. Each received byte is presented on o_data
//   together with a one-cycle o_rx_done_tick strobe and per-frame error flags.
//   The byte is delivered even when the stop bit is sampled low.
//
//   Optional feature: define RX_PARITY_EN to insert an even-parity bit
//   between the data bits and the stop bit. Without it the frame is 8N1 and
//   o_parity_err is tied low.
//
// Ports
//   i_clock         system clock, rising edge
//   i_reset         synchronous, active-high reset
//   i_rx            asynchronous serial input, idle high
//   i_s_tick        one-cycle enable, 16 per bit period
//   o_data          last received byte, held until the next done strobe
//   o_rx_done_tick  one-cycle pulse: o_data and error flags are valid
//   o_frame_err     stop bit of the last frame was sampled low
//   o_parity_err    parity mismatch on the last frame (0 without RX_PARITY_EN)
// -----------------------------------------------------------------------------
module rx_uart #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int NB_STATE = 3
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic [DBIT-1:0] o_data,
  output logic            o_rx_done_tick,
  output logic            o_frame_err,
  output logic            o_parity_err
);

  localparam int DCW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [NB_STATE-1:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // Input synchronizer and edge history. Reset to the idle (high) level so a
  // reset never manufactures a falling edge.
  logic rx_meta;
  logic rx_s;
  logic rx_d;

  state_t          state,      state_next;
  logic [3:0]      tick_cnt,   tick_next;
  logic [DCW-1:0]  data_cnt,   data_cnt_next;
  logic [DBIT-1:0] shiftreg,   shift_next;
  logic [DBIT-1:0] data_reg,   data_next;
  logic            ferr_reg,   ferr_next;
  logic            done_reg,   done_next;
`ifdef RX_PARITY_EN
  logic            parity_bit, parity_bit_next;
  logic            perr_reg,   perr_next;
`endif

  // NOTE: every clocked register uses non-blocking assignment so all flops
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      data_cnt <= '0;
      shiftreg <= '0;
      data_reg <= '0;
      ferr_reg <= 1'b0;
      done_reg <= 1'b0;
`ifdef RX_PARITY_EN
      parity_bit <= 1'b0;
      perr_reg   <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      tick_cnt <= tick_next;
      data_cnt <= data_cnt_next;
      shiftreg <= shift_next;
      data_reg <= data_next;
      ferr_reg <= ferr_next;
      done_reg <= done_next;
`ifdef RX_PARITY_EN
      parity_bit <= parity_bit_next;
      perr_reg   <= perr_next;
`endif
    end
  end

  // Next-state logic. Counters only move on tick cycles, so between ticks
  // every register simply holds.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned (which would infer a latch).
    state_next    = state;
    tick_next     = tick_cnt;
    data_cnt_next = data_cnt;
    shift_next    = shiftreg;
    data_next     = data_reg;
    ferr_next     = ferr_reg;
    done_next     = 1'b0;
`ifdef RX_PARITY_EN
    parity_bit_next = parity_bit;
    perr_next       = perr_reg;
`endif

    case (state)
      IDLE: begin
        // Only a high-to-low transition starts a frame; a line stuck low
        // has rx_d = 0 and cannot retrigger.
        if (rx_d && !rx_s) begin
          tick_next  = '0;
          state_next = START;
        end
      end

      START: begin
        if (i_s_tick) begin
          if (tick_cnt == 4'd7) begin
            tick_next = '0;
            if (!rx_s) begin
              data_cnt_next = '0;
              state_next    = DATA;
            end else begin
              // Line back high at mid start bit: a glitch, not a frame.
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end
      end

      DATA: begin
        if (i_s_tick) begin
          if (tick_cnt == 4'd15) begin
            tick_next  = '0;
            shift_next = {rx_s, shiftreg[DBIT-1:1]};
            if (data_cnt == DCW'(DBIT - 1)) begin
`ifdef RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              data_cnt_next = data_cnt + 1'b1;
            end
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end
      end

`ifdef RX_PARITY_EN
      PARITY: begin
        if (i_s_tick) begin
          if (tick_cnt == 4'd15) begin
            tick_next       = '0;
            parity_bit_next = rx_s;
            state_next      = STOP;
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end
      end
`endif

      STOP: begin
        if (i_s_tick) begin
          if (tick_cnt == 4'(SB_TICK - 1)) begin
            // Deliver the byte regardless of the stop-bit level; the
            // framing flag reports it instead.
            tick_next  = '0;
            data_next  = shiftreg;
            ferr_next  = ~rx_s;
            done_next  = 1'b1;
            state_next = IDLE;
`ifdef RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            perr_next = (^shiftreg) ^ parity_bit;
`endif
          end else begin
            tick_next = tick_cnt + 4'd1;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign o_data         = data_reg;
  assign o_rx_done_tick = done_reg;
  assign o_frame_err    = ferr_reg;
`ifdef RX_PARITY_EN
  assign o_parity_err   = perr_reg;
`else
  assign o_parity_err   = 1'b0;
`endif

endmodule

// File: doc/rx_uart.md
# rx_uart

UART receiver, the receive-side counterpart of the block's tx_uart transmitter; recovers 8N1 serial frames from `i_rx` using the shared 16x oversampling baud tick. Sits between the board RX pin and the debug/loader unit. Presents each received byte with a one-cycle done strobe and a per-frame error flag.

## Interface
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: oversampling ticks in the stop bit.
- `NB_STATE`, 3: state register width.
- `i_clock` in 1: system clock; all logic on rising edge.
- `i_reset` in 1: synchronous, active-high reset; clock `i_clock`.
- `i_rx` in 1: asynchronous serial input; idle high.
- `i_s_tick` in 1: one-cycle enable, 16 per bit period.
- `o_data` out DBIT: last received byte; holds until the next done strobe.
- `o_rx_done_tick` out 1: one-cycle pulse, `o_data` and error flags valid.
- `o_frame_err` out 1: stop bit sampled low on the last frame.
- `o_parity_err` out 1: parity mismatch on the last frame; constant 0 unless `RX_PARITY_EN`.

## Operation
- `i_rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`; the previous value is kept as `rx_d`.
- Counters: `tick_counter` 4 bits, `data_counter` 3 bits (`clog2(DBIT)`), `shiftreg` DBIT bits.
- IDLE: on a falling edge (`rx_d`=1, `rx_s`=0), clear `tick_counter` and go to START. A line held low does not retrigger; it must return high first.
- START: on each `i_s_tick`, increment. At `tick_counter`==7 (mid start bit):
  - if `rx_s`=0, clear counters and go to DATA;
  - if `rx_s`=1, it is a glitch: return to IDLE, no strobe, outputs unchanged.
- DATA: on each `i_s_tick`, increment. At 15: `shiftreg` <= {`rx_s`, `shiftreg[DBIT-1:1]`}, clear `tick_counter`. On `data_counter`==DBIT-1, go to STOP (or PARITY). Otherwise increment `data_counter`.
- STOP: on each `i_s_tick`, increment. At SB_TICK-1, sample `rx_s` and go to IDLE. On the next clock edge:
  - `o_data` <= `shiftreg`;
  - `o_frame_err` <= ~`rx_s`;
  - `o_rx_done_tick` = 1 for exactly one cycle.
- The byte is always delivered, even with a framing error.
- Ticks are counted only on cycles where `i_s_tick`=1. Between ticks, all state holds.

## Timing
- Reset values:
  - outputs: `o_data`=0, `o_rx_done_tick`=0, `o_frame_err`=0, `o_parity_err`=0;
  - internal: state=IDLE, counters=0, synchronizer=1.
- Input latency: 2 clocks from `i_rx` to `rx_s`.
- Sampling points: data and stop bits are sampled 16 ticks apart, starting 8 ticks after the detected falling edge, so each sample lands at mid-bit ±1 tick.
- `o_rx_done_tick` is registered. It asserts in the clock after the `i_s_tick` cycle that sampled the stop bit.
- Earliest new-start detection is the cycle after STOP→IDLE. Back-to-back frames with a one-bit stop are received without loss.
- Reset mid-frame: the partial frame is discarded, no strobe, and outputs return to their reset values.
- A falling edge arriving during STOP is ignored unless it is still low-going when seen in IDLE. A low `rx_s` in IDLE with `rx_d`=1 is a valid edge.

## Configuration
- `RX_PARITY_EN` defined:
  - a PARITY state is inserted between DATA and STOP;
  - one extra bit is sampled at tick 15, even parity;
  - `o_parity_err` <= XOR(`shiftreg`, parity bit), updated together with `o_rx_done_tick`.
- `RX_PARITY_EN` undefined: frame is 8N1, no PARITY state, `o_parity_err` tied 0.

## Test plan
- Bench setup: `i_s_tick` every 4 clocks (1 bit = 64 clocks).
- Frame 0xA5, valid stop → one `o_rx_done_tick` pulse, `o_data`=0xA5, `o_frame_err`=0. Pulse occurs 2 + (9.5×64) ±4 clocks after the falling edge.
- Frames 0x00 then 0xFF back-to-back, single stop bit → two strobes, values 0x00 then 0xFF, no errors.
- Low glitch of 3 ticks on idle line → no strobe, state returns to IDLE, `o_data` unchanged.
- Frame 0x3C with stop bit driven 0, then line held low for 20 bit times → `o_data`=0x3C, `o_frame_err`=1, exactly one strobe; no new frame until the line goes high and falls again.
- Reset asserted at data bit 4 of 0x81, then frame 0x7E → no strobe for the first frame; `o_data`=0x7E received correctly.
- With `RX_PARITY_EN`: 0x07 with parity bit 1 → `o_parity_err`=0; 0x07 with parity bit 0 → `o_parity_err`=1.
